// File: rtl/hall_pkg.sv
// Shared definitions for the hall-sensor front end: reserved codes, FSM
// encoding and the hall-code to commutation-index map.
package hall_pkg;

  localparam logic [2:0] HALL_DISCONNECTED = 3'b111;
  localparam logic [2:0] HALL_FAULT        = 3'b000;

  typedef enum logic [1:0] {
    NO_MOTOR = 2'd0,
    RUN      = 2'd1,
    FAULT    = 2'd2
  } hall_state_e;

  // Returns {valid, idx[2:0]}; the two reserved codes map to invalid.
  function automatic logic [3:0] hall_to_idx(input logic [2:0] code);
    case (code)
      3'b101:  hall_to_idx = {1'b1, 3'd0};
      3'b100:  hall_to_idx = {1'b1, 3'd1};
      3'b110:  hall_to_idx = {1'b1, 3'd2};
      3'b010:  hall_to_idx = {1'b1, 3'd3};
      3'b011:  hall_to_idx = {1'b1, 3'd4};
      3'b001:  hall_to_idx = {1'b1, 3'd5};
      default: hall_to_idx = {1'b0, 3'd0};
    endcase
  endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchronizer plus debounce for the three raw hall lines; the
// filtered code only moves after FILTER_CYCLES identical synchronized samples.
module hall_filter
  import hall_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic [2:0] raw,
  output logic [2:0] filt,
  output logic       filt_changed
);

  localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  // The sample that reloads the candidate counts as the first of the run.
  localparam int unsigned MATCH = (FILTER_CYCLES >= 2) ? FILTER_CYCLES - 2 : 0;

  logic [2:0]       sync1_q, sync1_d;
  logic [2:0]       sync2_q, sync2_d;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       filt_q, filt_d;
  logic             changed_q, changed_d;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    filt_d  = filt_q;
    if (FILTER_CYCLES == 1) begin
      cand_d = sync2_q;
      filt_d = sync2_q;
    end else if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_W'(MATCH)) begin
      filt_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    changed_d = (filt_d != filt_q);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= HALL_DISCONNECTED;
      sync2_q   <= HALL_DISCONNECTED;
      cand_q    <= HALL_DISCONNECTED;
      cnt_q     <= '0;
      filt_q    <= HALL_DISCONNECTED;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      filt_q    <= filt_d;
      changed_q <= changed_d;
    end
  end

  assign filt         = filt_q;
  assign filt_changed = changed_q;

endmodule

// File: rtl/hall_monitor.sv
// Per-motor hall front end: connection/fault FSM, commutation index tracking,
// signed transition counter with load port, and stall detection.
module hall_monitor
  import hall_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter int unsigned COUNT_WIDTH   = 8,
  parameter int unsigned STALL_WIDTH   = 22,
  parameter int unsigned STALL_CYCLES  = 2000000
) (
  input  logic                   sysclk,
  input  logic                   rst_n,
  input  logic                   hall_a,
  input  logic                   hall_b,
  input  logic                   hall_c,
  input  logic                   cnt_load,
  input  logic [COUNT_WIDTH-1:0] cnt_load_val,
  output logic                   connected,
  output logic                   fault,
  output logic [2:0]             step_idx,
  output logic                   step_strobe,
  output logic                   dir,
  output logic                   skip,
  output logic [COUNT_WIDTH-1:0] hall_count,
  output logic                   stall
);

  logic [2:0] filt;
  logic       filt_changed;

  hall_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .raw          ({hall_a, hall_b, hall_c}),
    .filt         (filt),
    .filt_changed (filt_changed)
  );

  hall_state_e            state_q, state_d;
  logic [2:0]             idx_q, idx_d;
  logic                   strobe_q, strobe_d;
  logic                   skip_q, skip_d;
  logic                   dir_q, dir_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [STALL_WIDTH-1:0] timer_q, timer_d;

  logic       code_valid;
  logic [2:0] new_idx;
  logic [2:0] delta;
  logic       inc, dec;

  always_comb begin
    {code_valid, new_idx} = hall_to_idx(filt);
    // Forward distance around the 6-step wheel; 3-bit wrap is harmless since
    // the result is always below 6.
    delta = (new_idx >= idx_q) ? new_idx - idx_q : new_idx + 3'd6 - idx_q;

    state_d  = state_q;
    idx_d    = idx_q;
    strobe_d = 1'b0;
    skip_d   = 1'b0;
    dir_d    = dir_q;
    inc      = 1'b0;
    dec      = 1'b0;

    if (filt_changed) begin
      case (state_q)
        NO_MOTOR: begin
          if (filt == HALL_FAULT) begin
            state_d = FAULT;
          end else if (code_valid) begin
            state_d = RUN;
            idx_d   = new_idx;
          end
        end
        RUN: begin
          if (filt == HALL_DISCONNECTED) begin
            state_d = NO_MOTOR;
          end else if (filt == HALL_FAULT) begin
            state_d = FAULT;
          end else if (code_valid) begin
            case (delta)
              3'd1: begin
                idx_d = new_idx; strobe_d = 1'b1; dir_d = 1'b1; inc = 1'b1;
              end
              3'd5: begin
                idx_d = new_idx; strobe_d = 1'b1; dir_d = 1'b0; dec = 1'b1;
              end
              3'd2, 3'd3, 3'd4: begin
                idx_d = new_idx; skip_d = 1'b1;
              end
              default: ;
            endcase
          end
        end
        FAULT: begin
          if (filt == HALL_DISCONNECTED) state_d = NO_MOTOR;
        end
        default: state_d = NO_MOTOR;
      endcase
    end

    // A host load wins over a same-cycle step, whose +/-1 is dropped.
    if (cnt_load)  count_d = cnt_load_val;
    else if (inc)  count_d = count_q + COUNT_WIDTH'(1);
    else if (dec)  count_d = count_q - COUNT_WIDTH'(1);
    else           count_d = count_q;

    if (state_d != RUN)                              timer_d = '0;
    else if (state_q != RUN || strobe_d || skip_d)   timer_d = '0;
    else if (timer_q != '1)                          timer_d = timer_q + STALL_WIDTH'(1);
    else                                             timer_d = timer_q;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NO_MOTOR;
      idx_q    <= 3'd0;
      strobe_q <= 1'b0;
      skip_q   <= 1'b0;
      dir_q    <= 1'b0;
      count_q  <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      strobe_q <= strobe_d;
      skip_q   <= skip_d;
      dir_q    <= dir_d;
      count_q  <= count_d;
      timer_q  <= timer_d;
    end
  end

  assign connected   = (state_q == RUN);
  assign fault       = (state_q == FAULT);
  assign step_idx    = idx_q;
  assign step_strobe = strobe_q;
  assign skip        = skip_q;
  assign dir         = dir_q;
  assign hall_count  = count_q;
  assign stall       = (state_q == RUN) && (timer_q >= STALL_WIDTH'(STALL_CYCLES));

endmodule
